// File: rtl/global_defs.sv
// Shared definitions for the parser-to-queue request path: opcodes, issuer
// states and the request word handed to the queue.
package global_defs;

  localparam int DEF_TIME_W = 64;
  localparam int DEF_ADDR_W = 33;

  typedef enum logic [1:0] {
    READ   = 2'd0,
    WRITE  = 2'd1,
    IFETCH = 2'd2
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TIME,
    ISSUE,
    DONE
  } issuer_state_t;

  typedef struct packed {
    logic                  op_ready_s;
    opcode_t               opcode;
    logic [DEF_ADDR_W-1:0] address;
    logic [DEF_TIME_W-1:0] time_cpu;
  } parser_out_struct_t;

endpackage

// File: rtl/issuer_stats.sv
// Saturating statistics for the request issuer: acceptances per opcode and
// cycles spent stalled on a full queue.
module issuer_stats #(
  parameter int STALL_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               accept,
  input  logic [1:0]         accept_opcode,
  input  logic               full_stall,
  output logic [STALL_W-1:0] stat_issued [0:2],
  output logic [STALL_W-1:0] stat_full_stall
);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        stat_issued[i] <= '0;
      end
      stat_full_stall <= '0;
    end else begin
      // An opcode of 3 never matches a counter and is simply not counted.
      for (int i = 0; i < 3; i++) begin
        if (accept && accept_opcode == 2'(i) && stat_issued[i] != '1) begin
          stat_issued[i] <= stat_issued[i] + 1'b1;
        end
      end
      if (full_stall && stat_full_stall != '1) begin
        stat_full_stall <= stat_full_stall + 1'b1;
      end
    end
  end

endmodule

// File: rtl/request_issuer.sv
// Producer side of the parser-to-queue interface: holds one trace entry,
// tracks simulated CPU time and issues the entry once due. Defining
// ISSUER_STATS_EN adds the STALL_W parameter and the statistics outputs.
module request_issuer
  import global_defs::*;
#(
  parameter int TIME_W = DEF_TIME_W,
  parameter int ADDR_W = DEF_ADDR_W
`ifdef ISSUER_STATS_EN
  ,
  parameter int STALL_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [TIME_W-1:0]  ld_time,
  input  logic [1:0]         ld_opcode,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic               ld_last,
  input  logic               queue_full,
  input  logic               queue_empty,
  output parser_out_struct_t out,
  output logic [TIME_W-1:0]  sim_time,
  output logic               done
`ifdef ISSUER_STATS_EN
  ,
  output logic [STALL_W-1:0] stat_issued [0:2],
  output logic [STALL_W-1:0] stat_full_stall
`endif
);

  issuer_state_t     state;
  logic [TIME_W-1:0] held_time;
  opcode_t           held_opcode;
  logic [ADDR_W-1:0] held_addr;
  logic              held_last;
  logic              rst_hold;
  logic              accept;

  // The loader is refused for the first cycle after reset releases.
  assign ld_ready = (state == IDLE) && !rst_hold;
  assign accept   = (state == ISSUE) && out.op_ready_s && !queue_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sim_time    <= '0;
      out         <= '0;
      done        <= 1'b0;
      rst_hold    <= 1'b1;
      held_time   <= '0;
      held_opcode <= READ;
      held_addr   <= '0;
      held_last   <= 1'b0;
    end else begin
      rst_hold <= 1'b0;
      case (state)
        IDLE: begin
          sim_time <= sim_time + 1'b1;
          if (ld_valid && ld_ready) begin
            held_time   <= ld_time;
            held_opcode <= opcode_t'(ld_opcode);
            held_addr   <= ld_addr;
            held_last   <= ld_last;
            state       <= WAIT_TIME;
          end
        end

        // An empty queue means nothing is in flight, so time can jump ahead.
        WAIT_TIME: begin
          if (sim_time >= held_time) begin
            sim_time <= sim_time + 1'b1;
            state    <= ISSUE;
          end else if (queue_empty) begin
            sim_time <= held_time;
            state    <= ISSUE;
          end else begin
            sim_time <= sim_time + 1'b1;
          end
        end

        // First ISSUE cycle presents the entry; it then stays frozen until taken.
        ISSUE: begin
          sim_time <= sim_time + 1'b1;
          if (!out.op_ready_s) begin
            out.op_ready_s <= 1'b1;
            out.opcode     <= held_opcode;
            out.address    <= held_addr;
            out.time_cpu   <= held_time;
          end else if (!queue_full) begin
            out.op_ready_s <= 1'b0;
            done           <= held_last;
            state          <= held_last ? DONE : IDLE;
          end
        end

        DONE: begin
          sim_time <= sim_time + 1'b1;
          done     <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef ISSUER_STATS_EN
  issuer_stats #(
    .STALL_W(STALL_W)
  ) u_stats (
    .clk            (clk),
    .rst            (rst),
    .accept         (accept),
    .accept_opcode  (out.opcode),
    .full_stall     ((state == ISSUE) && out.op_ready_s && queue_full),
    .stat_issued    (stat_issued),
    .stat_full_stall(stat_full_stall)
  );
`endif

endmodule
